arb_hs_sink: RTL and testbench
==============================

Name: arb_hs_sink

Overview:
- Clocked consumer sitting directly downstream of the 2-input asynchronous arbiter.
- Terminates the arbiter's 4-phase request/acknowledge output channel (req, ack, sel) in the synchronous domain.
- Delivers one valid/ready transaction per granted request to clocked logic, tagged with the winning channel.
- Keeps per-channel grant counters and flags protocol violations.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the req/sel synchronizers (legal 2..4)
CNT_W, 8, width of each per-channel grant counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_in  input  1  arbiter request output (asynchronous, 4-phase)
sel_in  input  1  arbiter selection bit; stable whenever req_in is high
ack_out  output  1  acknowledge back to arbiter (registered)
grant_valid  output  1  transaction offered to synchronous consumer
grant_sel  output  1  winning channel of offered transaction (0 or 1)
grant_ready  input  1  consumer accepts the transaction
cnt_clr  input  1  synchronous clear of both grant counters
grant_cnt0  output  CNT_W  accepted grants for channel 0, wraps modulo 2^CNT_W
grant_cnt1  output  CNT_W  accepted grants for channel 1, wraps modulo 2^CNT_W
busy  output  1  FSM not in IDLE
err_proto  output  1  sticky protocol-error flag

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (async assert, sync deassert assumed upstream):
  - ack_out, grant_valid, grant_sel, busy and err_proto = 0.
  - Both counters = 0; synchronizer chains = 0; FSM = IDLE.
  - Reset mid-handshake drops ack_out immediately, with no further transitions.
- Synchronizers:
  - req_in and sel_in each pass through SYNC_STAGES flops, giving req_s and sel_s.
  - Both chains have equal depth, so sel_s is valid whenever req_s is high.
- FSM states: IDLE, OFFER, ACK, DRAIN.
  - IDLE: ack_out=0. When req_s=1, capture grant_sel<=sel_s and go to OFFER.
  - OFFER: grant_valid=1; grant_sel is held constant.
    - On grant_valid&grant_ready, increment the counter selected by grant_sel.
    - If req_s is still 1, go to ACK. Otherwise go to DRAIN.
    - grant_valid must not drop without acceptance.
  - ACK: ack_out=1. Stay until req_s=0, then go to IDLE with ack_out=0 on the same edge.
  - DRAIN: entered only after premature request withdrawal. ack_out stays 0. Go to IDLE when req_s=0.
- Latency:
  - req_in rise to grant_valid=1 is SYNC_STAGES+1 clk edges.
  - With grant_ready held high, accept to ack_out=1 is 1 edge.
  - req_in fall to ack_out=0 is SYNC_STAGES+1 edges.
  - The next request is not recognised before ack_out=0 has been registered.
- Minimum full handshake with grant_ready=1 is 2*(SYNC_STAGES+1)+1 cycles.
- err_proto is set (sticky until reset) when either of these occurs:
  - req_s falls while in OFFER. The transaction is still delivered, ack_out is never raised, and the FSM passes through DRAIN.
  - sel_s differs from grant_sel while req_s=1 in OFFER or ACK.
- Counters:
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
  - Counters wrap from 2^CNT_W-1 to 0 and do not saturate.
- busy = (state != IDLE).
- grant_sel holds its last value while in IDLE.

Test Plan:
- Reset, then a single channel-1 request: req_in=1, sel_in=1, grant_ready=1 -> grant_valid high at edge 3 with grant_sel=1; ack_out=1 one edge later; req_in=0 -> ack_out=0 after 3 edges; grant_cnt1=1, grant_cnt0=0, err_proto=0.
- Backpressure: grant_ready=0 for 10 cycles during OFFER -> grant_valid and grant_sel stable, ack_out stays 0; ready at cycle 11 -> ack_out rises next edge; counter increments exactly once.
- Alternating 4-phase sequence 0,1,0,1,1 driven by a behavioural arbiter model -> grant_sel stream matches; grant_cnt0=2, grant_cnt1=3; no overlap of ack_out with a new capture.
- Wrap and clear with CNT_W=4: 16 channel-0 grants -> grant_cnt0=0. Then assert cnt_clr in the same cycle as an accept -> grant_cnt0=0.
- Protocol errors:
  - req_in dropped during OFFER -> err_proto=1, ack_out never rises, FSM returns to IDLE.
  - sel_in toggled while req high -> err_proto=1.
- Reset mid-ACK: assert rst_n=0 while ack_out=1 -> ack_out=0 and busy=0 immediately, without waiting for a clock edge; counters=0.

Source files
------------

// File: rtl/arb_hs_sink_if.sv
// Bundles the arbiter 4-phase channel, the grant valid/ready channel and status.
interface arb_hs_sink_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req_in;
  logic             sel_in;
  logic             ack_out;
  logic             grant_valid;
  logic             grant_sel;
  logic             grant_ready;
  logic             cnt_clr;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
  logic             busy;
  logic             err_proto;

  // Sink side: consumes req/sel, produces ack and the synchronous grant.
  modport slave (
    input  req_in, sel_in, grant_ready, cnt_clr,
    output ack_out, grant_valid, grant_sel, grant_cnt0, grant_cnt1, busy, err_proto
  );

  // Environment side: arbiter plus synchronous consumer.
  modport master (
    output req_in, sel_in, grant_ready, cnt_clr,
    input  ack_out, grant_valid, grant_sel, grant_cnt0, grant_cnt1, busy, err_proto
  );
endinterface

// File: rtl/arb_hs_sink.sv
// Clocked terminator for the asynchronous arbiter's 4-phase req/ack channel.
// Each granted request becomes one valid/ready transaction tagged with the
// winning channel; per-channel grant counters and a sticky protocol flag.
module arb_hs_sink #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_hs_sink_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic [1:0]             r_state;
  logic                   r_ack;
  logic                   r_valid;
  logic                   r_sel;
  logic                   r_busy;
  logic                   r_err;
  logic [CNT_W-1:0]       r_cnt0;
  logic [CNT_W-1:0]       r_cnt1;

  logic                   w_req_s;
  logic                   w_sel_s;
  logic                   w_accept;
  logic [1:0]             w_state_nxt;
  logic                   w_sel_nxt;
  logic                   w_err_nxt;
  logic [CNT_W-1:0]       w_cnt0_nxt;
  logic [CNT_W-1:0]       w_cnt1_nxt;

  assign w_req_s  = r_req_sync[SYNC_STAGES-1];
  assign w_sel_s  = r_sel_sync[SYNC_STAGES-1];
  assign w_accept = (r_state == S_OFFER) && bus.grant_ready;

  // Equal-depth synchronizers keep sel_s aligned with req_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync <= '0;
      r_sel_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], bus.req_in};
      r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], bus.sel_in};
    end
  end

  // Next-state, capture, error and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_err_nxt   = r_err;
    w_cnt0_nxt  = r_cnt0;
    w_cnt1_nxt  = r_cnt1;

    case (r_state)
      S_IDLE: begin
        if (w_req_s) begin
          w_sel_nxt   = w_sel_s;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        // Withdrawal before ack is a violation, but the offer is still held.
        if (!w_req_s) begin
          w_err_nxt = 1'b1;
        end else if (w_sel_s != r_sel) begin
          w_err_nxt = 1'b1;
        end
        if (w_accept) begin
          w_state_nxt = w_req_s ? S_ACK : S_DRAIN;
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
        end else if (w_sel_s != r_sel) begin
          w_err_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Clear wins over a same-cycle increment; counters wrap naturally.
    if (bus.cnt_clr) begin
      w_cnt0_nxt = '0;
      w_cnt1_nxt = '0;
    end else if (w_accept) begin
      if (r_sel) begin
        w_cnt1_nxt = r_cnt1 + CNT_W'(1);
      end else begin
        w_cnt0_nxt = r_cnt0 + CNT_W'(1);
      end
    end
  end

  // State and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == S_ACK);
      r_valid <= (w_state_nxt == S_OFFER);
      r_sel   <= w_sel_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= w_err_nxt;
      r_cnt0  <= w_cnt0_nxt;
      r_cnt1  <= w_cnt1_nxt;
    end
  end

  assign bus.ack_out     = r_ack;
  assign bus.grant_valid = r_valid;
  assign bus.grant_sel   = r_sel;
  assign bus.busy        = r_busy;
  assign bus.err_proto   = r_err;
  assign bus.grant_cnt0  = r_cnt0;
  assign bus.grant_cnt1  = r_cnt1;

endmodule

// File: tb/tb_arb_hs_sink.sv
// Bench for arb_hs_sink: behavioural 4-phase arbiter, grant scoreboard,
// counter model and per-scenario checks.
module tb_arb_hs_sink;

  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_hs_sink_if #(.CNT_W(CNT_W)) bus ();

  arb_hs_sink #(.SYNC_STAGES(2), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_overlap = 0;
  bit sb_q[$];
  bit m_exp;
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;

  // Scoreboard monitor: every accepted grant pops the expected channel.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack_out && bus.grant_valid) n_overlap++;
      if (bus.grant_valid && bus.grant_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: accepted sel=%0b, nothing expected", bus.grant_sel);
          m_exp = bus.grant_sel;
        end else begin
          m_exp = sb_q.pop_front();
          if (bus.grant_sel !== m_exp) begin
            n_fail++;
            $display("FAIL sb_grant_sel: got %0b expected %0b", bus.grant_sel, m_exp);
          end
        end
      end
      if (bus.cnt_clr) begin
        m_cnt0 = '0;
        m_cnt1 = '0;
      end else if (bus.grant_valid && bus.grant_ready) begin
        if (m_exp) m_cnt1 = m_cnt1 + CNT_W'(1);
        else       m_cnt0 = m_cnt0 + CNT_W'(1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_in = 1'b0;
    bus.sel_in = 1'b0;
    bus.grant_ready = 1'b0;
    bus.cnt_clr = 1'b0;
    sb_q.delete();
    m_cnt0 = '0;
    m_cnt1 = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Behavioural arbiter: one full 4-phase handshake, ready after wait_cycles.
  task automatic hs(input bit sel, input int wait_cycles);
    int n;
    sb_q.push_back(sel);
    bus.sel_in = sel;
    bus.req_in = 1'b1;
    bus.grant_ready = (wait_cycles == 0);
    n = 0;
    while (!bus.grant_valid && n < 20) begin tick(); n++; end
    n_checks++;
    if (!bus.grant_valid) begin
      n_fail++;
      $display("FAIL hs_valid_timeout: grant_valid=%0b after %0d cycles, required 1", bus.grant_valid, n);
    end
    repeat (wait_cycles) tick();
    bus.grant_ready = 1'b1;
    n = 0;
    while (!bus.ack_out && n < 20) begin tick(); n++; end
    n_checks++;
    if (!bus.ack_out) begin
      n_fail++;
      $display("FAIL hs_ack_timeout: ack_out=%0b, required 1", bus.ack_out);
    end
    bus.req_in = 1'b0;
    n = 0;
    while (bus.ack_out && n < 20) begin tick(); n++; end
    n_checks++;
    if (bus.ack_out) begin
      n_fail++;
      $display("FAIL hs_release_timeout: ack_out=%0b, required 0", bus.ack_out);
    end
  endtask

  task automatic test_reset();
    logic [2*CNT_W+4:0] obs;
    rst_n = 1'b0;
    bus.req_in = 1'b0;
    bus.sel_in = 1'b0;
    bus.grant_ready = 1'b0;
    bus.cnt_clr = 1'b0;
    repeat (3) tick();
    obs = {bus.ack_out, bus.grant_valid, bus.grant_sel, bus.busy, bus.err_proto,
           bus.grant_cnt0, bus.grant_cnt1};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst_n = 1'b1;
    tick();
    obs = {bus.ack_out, bus.grant_valid, bus.grant_sel, bus.busy, bus.err_proto,
           bus.grant_cnt0, bus.grant_cnt1};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_single();
    sb_q.push_back(1'b1);
    bus.sel_in = 1'b1;
    bus.req_in = 1'b1;
    bus.grant_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: grant_valid=%0b at edge 2, required 0", bus.grant_valid);
    end
    tick();
    n_checks++;
    if ({bus.grant_valid, bus.grant_sel, bus.busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL single_valid_edge3: valid/sel/busy=%b required 111",
               {bus.grant_valid, bus.grant_sel, bus.busy});
    end
    tick();
    n_checks++;
    if ({bus.ack_out, bus.grant_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ack: ack/valid=%b required 10", {bus.ack_out, bus.grant_valid});
    end
    bus.req_in = 1'b0;
    tick(); tick();
    n_checks++;
    if (bus.ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack_hold: ack_out=%0b at edge 2 after release, required 1", bus.ack_out);
    end
    tick();
    n_checks++;
    if ({bus.ack_out, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_release: ack/busy=%b required 00", {bus.ack_out, bus.busy});
    end
    n_checks++;
    if (bus.grant_cnt1 !== CNT_W'(1) || bus.grant_cnt0 !== CNT_W'(0) || bus.err_proto !== 1'b0) begin
      n_fail++;
      $display("FAIL single_counts: cnt0=%0d cnt1=%0d err=%0b required 0 1 0",
               bus.grant_cnt0, bus.grant_cnt1, bus.err_proto);
    end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] c0;
    int bad;
    c0 = bus.grant_cnt0;
    sb_q.push_back(1'b0);
    bus.sel_in = 1'b0;
    bus.req_in = 1'b1;
    bus.grant_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid: grant_valid=%0b required 1", bus.grant_valid);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.grant_valid !== 1'b1 || bus.grant_sel !== 1'b0 || bus.ack_out !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
    end
    bus.grant_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.ack_out, bus.grant_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_ack: ack/valid=%b required 10", {bus.ack_out, bus.grant_valid});
    end
    bus.req_in = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.grant_cnt0 !== c0 + CNT_W'(1) || bus.grant_cnt0 !== m_cnt0) begin
      n_fail++;
      $display("FAIL bp_count: cnt0=%0d required %0d", bus.grant_cnt0, c0 + CNT_W'(1));
    end
  endtask

  task automatic test_alternating();
    bit seq[5];
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    n_overlap = 0;
    for (int i = 0; i < 5; i++) hs(seq[i], i % 3);
    n_checks++;
    if (bus.grant_cnt0 !== CNT_W'(2) || bus.grant_cnt1 !== CNT_W'(3)) begin
      n_fail++;
      $display("FAIL alt_counts: cnt0=%0d cnt1=%0d required 2 3", bus.grant_cnt0, bus.grant_cnt1);
    end
    n_checks++;
    if (n_overlap != 0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL alt_overlap: overlaps=%0d pending=%0d required 0 0", n_overlap, sb_q.size());
    end
  endtask

  task automatic test_wrap_clear();
    int n;
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    repeat (16) hs(1'b0, 0);
    n_checks++;
    if (bus.grant_cnt0 !== CNT_W'(0) || bus.grant_cnt0 !== m_cnt0) begin
      n_fail++;
      $display("FAIL wrap_cnt0: cnt0=%0d required 0", bus.grant_cnt0);
    end
    hs(1'b0, 0);
    n_checks++;
    if (bus.grant_cnt0 !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL wrap_next: cnt0=%0d required 1", bus.grant_cnt0);
    end
    sb_q.push_back(1'b0);
    bus.sel_in = 1'b0;
    bus.req_in = 1'b1;
    bus.grant_ready = 1'b0;
    n = 0;
    while (!bus.grant_valid && n < 20) begin tick(); n++; end
    bus.grant_ready = 1'b1;
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    n_checks++;
    if (bus.grant_cnt0 !== CNT_W'(0) || bus.ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_priority: cnt0=%0d ack=%0b required 0 1", bus.grant_cnt0, bus.ack_out);
    end
    bus.req_in = 1'b0;
    n = 0;
    while (bus.ack_out && n < 20) begin tick(); n++; end
  endtask

  task automatic test_proto_drop();
    int acks;
    do_reset();
    sb_q.push_back(1'b1);
    bus.sel_in = 1'b1;
    bus.req_in = 1'b1;
    bus.grant_ready = 1'b0;
    repeat (3) tick();
    bus.req_in = 1'b0;
    acks = 0;
    repeat (3) begin tick(); if (bus.ack_out) acks++; end
    n_checks++;
    if ({bus.err_proto, bus.grant_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL drop_err: err/valid=%b required 11", {bus.err_proto, bus.grant_valid});
    end
    bus.grant_ready = 1'b1;
    tick();
    if (bus.ack_out) acks++;
    n_checks++;
    if ({bus.busy, bus.grant_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL drop_drain: busy/valid=%b required 10", {bus.busy, bus.grant_valid});
    end
    tick();
    if (bus.ack_out) acks++;
    n_checks++;
    if (bus.busy !== 1'b0 || acks != 0 || bus.grant_cnt1 !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%0b acks=%0d cnt1=%0d required 0 0 1",
               bus.busy, acks, bus.grant_cnt1);
    end
  endtask

  task automatic test_proto_sel();
    int n;
    do_reset();
    sb_q.push_back(1'b0);
    bus.sel_in = 1'b0;
    bus.req_in = 1'b1;
    bus.grant_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.err_proto !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_clean: err_proto=%0b required 0", bus.err_proto);
    end
    bus.sel_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.err_proto, bus.grant_sel} !== 2'b10) begin
      n_fail++;
      $display("FAIL sel_err: err/grant_sel=%b required 10", {bus.err_proto, bus.grant_sel});
    end
    bus.grant_ready = 1'b1;
    tick();
    bus.req_in = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset_mid_ack();
    int n;
    do_reset();
    hs(1'b0, 0);
    sb_q.push_back(1'b1);
    bus.sel_in = 1'b1;
    bus.req_in = 1'b1;
    bus.grant_ready = 1'b1;
    n = 0;
    while (!bus.ack_out && n < 20) begin tick(); n++; end
    n_checks++;
    if (bus.ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midack_setup: ack_out=%0b required 1", bus.ack_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.ack_out, bus.busy, bus.grant_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL midack_async: ack/busy/valid=%b required 000",
               {bus.ack_out, bus.busy, bus.grant_valid});
    end
    n_checks++;
    if (bus.grant_cnt0 !== CNT_W'(0) || bus.grant_cnt1 !== CNT_W'(0) || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL midack_counts: cnt0=%0d cnt1=%0d pending=%0d required 0 0 0",
               bus.grant_cnt0, bus.grant_cnt1, sb_q.size());
    end
    bus.req_in = 1'b0;
    m_cnt0 = '0;
    m_cnt1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({bus.ack_out, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL midack_after: ack/busy=%b required 00", {bus.ack_out, bus.busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_alternating();
    test_wrap_clear();
    test_proto_drop();
    test_proto_sel();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
